turf_udp_framer: RTL and testbench

TURF_UDP_FRAMER -- requirements
Module: turf_udp_framer

---
 rtl/turf_net_pkg.sv | 37 +++
 rtl/turf_ip_csum.sv | 25 ++
 rtl/turf_udp_framer.sv | 104 ++++++++++
 tb/tb_turf_udp_framer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/turf_net_pkg.sv
// turf_net: shared Ethernet/IPv4/UDP constants, framer states and byte-lane helpers
package turf_net;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0] IP_PROTO_UDP = 8'h11;
  localparam int HDR_BYTES = 42;
  localparam logic [7:0] DEFAULT_TTL = 8'd64;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CSUM = 3'd1;
  localparam logic [2:0] HDR = 3'd2;
  localparam logic [2:0] MERGE = 3'd3;
  localparam logic [2:0] PAYLOAD = 3'd4;
  localparam logic [2:0] TAIL = 3'd5;
  typedef struct packed {
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
  } cfg_t;
  function automatic logic [3:0] keep_cnt(input logic [7:0] keep);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, keep[i]};
    return c;
  endfunction
  function automatic logic [7:0] low_ones(input logic [3:0] n);
    logic [15:0] t;
    t = (16'd1 << n) - 16'd1;
    return t[7:0];
  endfunction
  function automatic logic [63:0] mask_bytes(input logic [63:0] d, input logic [7:0] keep);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = keep[i] ? d[8*i +: 8] : 8'h00;
    return r;
  endfunction
endpackage

// File: rtl/turf_ip_csum.sv
// turf_ip_csum: IPv4 header checksum, one adder tree folded end-around and registered on en
module turf_ip_csum
  import turf_net::*;
(
  input  logic        aclk,
  input  logic        areset,
  input  logic        en,
  input  logic [15:0] total_len,
  input  logic [15:0] ip_id,
  input  logic [7:0]  ttl,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  output logic [15:0] csum
);
  logic [19:0] sum;
  logic [16:0] fold1;
  logic [15:0] fold2;
  assign sum = 20'h04500 + 20'(total_len) + 20'(ip_id) + 20'h04000 + 20'({ttl, IP_PROTO_UDP})
             + 20'(src_ip[31:16]) + 20'(src_ip[15:0]) + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
  assign fold1 = 17'(sum[15:0]) + 17'(sum[19:16]);
  assign fold2 = fold1[15:0] + 16'(fold1[16]);
  always_ff @(posedge aclk)
    if (areset) csum <= '0;
    else if (en) csum <= ~fold2;
endmodule

// File: rtl/turf_udp_framer.sv
// turf_udp_framer: wraps a 64-bit UDP payload stream in an Ethernet II/IPv4/UDP header
module turf_udp_framer
  import turf_net::*;
#(
  parameter logic [7:0]  TTL   = DEFAULT_TTL,
  parameter logic [15:0] IP_ID = 16'h0000
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [47:0] dst_mac_i,
  input  logic [47:0] src_mac_i,
  input  logic [31:0] src_ip_i,
  input  logic [31:0] dst_ip_i,
  input  logic [15:0] src_port_i,
  input  logic [15:0] dst_port_i,
  input  logic [15:0] s_hdr_tdata,
  input  logic        s_hdr_tvalid,
  output logic        s_hdr_tready,
  input  logic [63:0] s_payload_tdata,
  input  logic [7:0]  s_payload_tkeep,
  input  logic        s_payload_tlast,
  input  logic        s_payload_tuser,
  input  logic        s_payload_tvalid,
  output logic        s_payload_tready,
  output logic [63:0] m_frame_tdata,
  output logic [7:0]  m_frame_tkeep,
  output logic        m_frame_tlast,
  output logic        m_frame_tvalid,
  input  logic        m_frame_tready,
  output logic        length_err_o
);
  logic [2:0] state, beat;
  cfg_t cfg;
  logic [15:0] len, cnt, hold, csum, total_len, udp_len, tot;
  logic [3:0] k, tail_n;
  logic bad, in_pay, last_k, unused_tuser;
  logic [319:0] hdr_be, hdr_le;
  logic [63:0] raw;
  assign unused_tuser = s_payload_tuser;
  assign total_len = len + 16'(HDR_BYTES - 14);
  assign udp_len = len + 16'(HDR_BYTES - 34);
  turf_ip_csum u_csum (
    .aclk(aclk), .areset(areset), .en(state == CSUM), .total_len(total_len), .ip_id(IP_ID),
    .ttl(TTL), .src_ip(cfg.src_ip), .dst_ip(cfg.dst_ip), .csum(csum)
  );
  // Header bytes 0-39; bytes 40-41 (UDP checksum, zero) ride as the held-over pair of the merge beat
  assign hdr_be = {cfg.dst_mac, cfg.src_mac, ETHERTYPE_IPV4, 8'h45, 8'h00, total_len, IP_ID, 16'h4000,
                   TTL, IP_PROTO_UDP, csum, cfg.src_ip, cfg.dst_ip, cfg.src_port, cfg.dst_port, udp_len};
  assign hdr_le = {<<8{hdr_be}};
  assign in_pay = state == MERGE || state == PAYLOAD;
  assign k = keep_cnt(s_payload_tkeep);
  assign tot = cnt + 16'(k);
  assign last_k = s_payload_tlast && k <= 4'd6;
  assign s_hdr_tready = state == IDLE && !areset;
  assign s_payload_tready = in_pay && m_frame_tready;
  assign m_frame_tvalid = state == HDR || state == TAIL || (in_pay && s_payload_tvalid);
  assign m_frame_tkeep = state == HDR ? 8'hFF : state == TAIL ? low_ones(tail_n) :
                         in_pay && s_payload_tvalid ? (last_k ? low_ones(4'(k + 4'd2)) : 8'hFF) : 8'h00;
  assign m_frame_tlast = state == TAIL || (in_pay && s_payload_tvalid && last_k);
  assign raw = state == HDR ? hdr_le[beat*64 +: 64] : state == TAIL ? {48'h0, hold} : {s_payload_tdata[47:0], hold};
  assign m_frame_tdata = mask_bytes(raw, m_frame_tkeep);
  assign length_err_o = m_frame_tvalid && m_frame_tready && m_frame_tlast && (state == TAIL ? bad : tot != len);
  always_ff @(posedge aclk)
    if (areset) begin
      state <= IDLE;
      beat <= '0;
      cnt <= '0;
      hold <= '0;
      tail_n <= '0;
      bad <= 1'b0;
    end else
      case (state)
        IDLE: if (s_hdr_tvalid) begin
          len <= s_hdr_tdata;
          cfg <= '{dst_mac_i, src_mac_i, src_ip_i, dst_ip_i, src_port_i, dst_port_i};
          state <= CSUM;
        end
        CSUM: begin
          beat <= '0;
          state <= HDR;
        end
        HDR: if (m_frame_tready) begin
          beat <= beat + 3'd1;
          if (beat == 3'd4) begin
            hold <= '0;
            cnt <= '0;
            state <= MERGE;
          end
        end
        MERGE, PAYLOAD: if (s_payload_tvalid && m_frame_tready) begin
          cnt <= tot;
          hold <= s_payload_tdata[63:48];
          if (!s_payload_tlast) state <= PAYLOAD;
          else if (last_k) state <= IDLE;
          else begin
            tail_n <= 4'(k - 4'd6);
            bad <= tot != len;
            state <= TAIL;
          end
        end
        TAIL: if (m_frame_tready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_turf_udp_framer.sv
// tb_turf_udp_framer: directed and random-backpressure checks of the UDP framer against a byte model
module tb_turf_udp_framer;
  logic aclk = 1'b0, areset = 1'b1;
  logic [47:0] dst_mac_i = 48'h02_11_22_33_44_55, src_mac_i = 48'h02_aa_bb_cc_dd_ee;
  logic [31:0] src_ip_i = 32'h0a000001, dst_ip_i = 32'h0a000002;
  logic [15:0] src_port_i = 16'd1234, dst_port_i = 16'd5678;
  logic [15:0] s_hdr_tdata = '0;
  logic s_hdr_tvalid = 1'b0, s_hdr_tready;
  logic [63:0] s_payload_tdata = '0;
  logic [7:0] s_payload_tkeep = '0;
  logic s_payload_tlast = 1'b0, s_payload_tuser = 1'b0, s_payload_tvalid = 1'b0, s_payload_tready;
  logic [63:0] m_frame_tdata;
  logic [7:0] m_frame_tkeep;
  logic m_frame_tlast, m_frame_tvalid, m_frame_tready = 1'b1, length_err_o;
  int errors = 0, checks = 0;
  bit rand_rdy = 1'b0;
  logic [7:0] exp_q[$];
  int len_q[$];
  bit err_q[$];
  logic [7:0] pay [0:63];
  int cur_rem = 0, done = 0, beat_i = 0, fr_beats = 0, n_m;
  bit cur_err = 1'b0, fr_err = 1'b0, pstall = 1'b0;
  logic [63:0] fr_b2, fr_b3, ed, pd;
  logic [7:0] fr_keep, ek, pk, tmp;
  logic pl;

  turf_udp_framer dut (
    .aclk(aclk), .areset(areset), .dst_mac_i(dst_mac_i), .src_mac_i(src_mac_i), .src_ip_i(src_ip_i),
    .dst_ip_i(dst_ip_i), .src_port_i(src_port_i), .dst_port_i(dst_port_i), .s_hdr_tdata(s_hdr_tdata),
    .s_hdr_tvalid(s_hdr_tvalid), .s_hdr_tready(s_hdr_tready), .s_payload_tdata(s_payload_tdata),
    .s_payload_tkeep(s_payload_tkeep), .s_payload_tlast(s_payload_tlast), .s_payload_tuser(s_payload_tuser),
    .s_payload_tvalid(s_payload_tvalid), .s_payload_tready(s_payload_tready), .m_frame_tdata(m_frame_tdata),
    .m_frame_tkeep(m_frame_tkeep), .m_frame_tlast(m_frame_tlast), .m_frame_tvalid(m_frame_tvalid),
    .m_frame_tready(m_frame_tready), .length_err_o(length_err_o)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  initial forever begin
    @(posedge aclk);
    #1;
    m_frame_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Monitor: sample at the falling edge, slice the expected byte stream into beats
  always @(negedge aclk) begin
    if (areset) begin
      while (cur_rem > 0) begin
        tmp = exp_q.pop_front();
        cur_rem--;
      end
      pstall = 1'b0;
      beat_i = 0;
    end else begin
      if (pstall) begin
        chk("stall_valid", m_frame_tvalid, 1);
        chk("stall_data", m_frame_tdata, pd);
        chk("stall_keep", m_frame_tkeep, pk);
        chk("stall_last", m_frame_tlast, pl);
      end
      if (m_frame_tvalid && m_frame_tready) begin
        if (cur_rem == 0) begin
          chk("unexpected_beat", len_q.size() > 0, 1);
          if (len_q.size() > 0) begin
            cur_rem = len_q.pop_front();
            cur_err = err_q.pop_front();
            beat_i = 0;
          end
        end
        if (cur_rem > 0) begin
          n_m = cur_rem < 8 ? cur_rem : 8;
          ed = '0;
          ek = '0;
          for (int i = 0; i < n_m; i++) begin
            ed[8*i +: 8] = exp_q.pop_front();
            ek[i] = 1'b1;
          end
          cur_rem -= n_m;
          chk("beat_data", m_frame_tdata, ed);
          chk("beat_keep", m_frame_tkeep, ek);
          chk("beat_last", m_frame_tlast, cur_rem == 0);
          chk("beat_len_err", length_err_o, cur_rem == 0 && cur_err);
          if (beat_i == 2) fr_b2 = m_frame_tdata;
          if (beat_i == 3) fr_b3 = m_frame_tdata;
          beat_i++;
          if (cur_rem == 0) begin
            fr_beats = beat_i;
            fr_keep = m_frame_tkeep;
            fr_err = length_err_o;
            done++;
          end
        end
      end else chk("len_err_idle", length_err_o, 0);
      pstall = m_frame_tvalid && !m_frame_tready;
      pd = m_frame_tdata;
      pk = m_frame_tkeep;
      pl = m_frame_tlast;
    end
  end

  task automatic model_push(input int L, input int nb);
    logic [15:0] tl, ul, cs;
    logic [335:0] h;
    int s;
    for (int i = 0; i < nb; i++) pay[i] = 8'($urandom);
    tl = 16'(L + 28);
    ul = 16'(L + 8);
    s = 'h4500 + int'(tl) + 'h4000 + 'h4011 + int'(src_ip_i[31:16]) + int'(src_ip_i[15:0])
      + int'(dst_ip_i[31:16]) + int'(dst_ip_i[15:0]);
    while (s > 'hFFFF) s = (s & 'hFFFF) + (s >> 16);
    cs = ~16'(s);
    h = {dst_mac_i, src_mac_i, 16'h0800, 16'h4500, tl, 16'h0000, 16'h4000, 16'h4011, cs,
         src_ip_i, dst_ip_i, src_port_i, dst_port_i, ul, 16'h0000};
    for (int i = 0; i < 42; i++) exp_q.push_back(h[335-8*i -: 8]);
    for (int i = 0; i < nb; i++) exp_q.push_back(pay[i]);
    len_q.push_back(42 + nb);
    err_q.push_back(nb != L);
  endtask

  task automatic hdr_send(input int L);
    int t;
    s_hdr_tdata = 16'(L);
    s_hdr_tvalid = 1'b1;
    t = 0;
    @(negedge aclk);
    while (!s_hdr_tready && t < 500) begin
      @(negedge aclk);
      t++;
    end
    chk("hdr_wait", s_hdr_tready, 1);
    cyc();
    s_hdr_tvalid = 1'b0;
  endtask

  task automatic pay_send(input int nb);
    int t, n;
    logic [63:0] d;
    logic [7:0] kp;
    for (int off = 0; off < nb; off += 8) begin
      n = (nb - off) < 8 ? nb - off : 8;
      d = {$urandom, $urandom};
      kp = '0;
      for (int i = 0; i < n; i++) begin
        d[8*i +: 8] = pay[off+i];
        kp[i] = 1'b1;
      end
      s_payload_tdata = d;
      s_payload_tkeep = kp;
      s_payload_tlast = off + 8 >= nb;
      s_payload_tvalid = 1'b1;
      t = 0;
      @(negedge aclk);
      while (!s_payload_tready && t < 500) begin
        @(negedge aclk);
        t++;
      end
      chk("pay_wait", s_payload_tready, 1);
      cyc();
    end
    s_payload_tvalid = 1'b0;
    s_payload_tlast = 1'b0;
  endtask

  task automatic send_frame(input int L, input int nb, input bit lat);
    model_push(L, nb);
    hdr_send(L);
    if (lat) begin
      chk("csum_cycle_valid", m_frame_tvalid, 0);
      cyc();
      chk("first_valid", m_frame_tvalid, 1);
    end
    pay_send(nb);
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done < target && t < 3000) begin
      cyc();
      t++;
    end
    chk("frame_done", done, target);
  endtask

  initial begin
    cyc();
    cyc();
    cyc();
    chk("rst_hdr_ready", s_hdr_tready, 0);
    chk("rst_pay_ready", s_payload_tready, 0);
    chk("rst_valid", m_frame_tvalid, 0);
    chk("rst_last", m_frame_tlast, 0);
    chk("rst_len_err", length_err_o, 0);
    areset = 1'b0;
    #1;
    chk("post_rst_hdr_ready", s_hdr_tready, 1);
    cyc();
    send_frame(8, 8, 1);
    wait_done(1);
    chk("l8_beats", fr_beats, 7);
    chk("l8_total_len", {fr_b2[7:0], fr_b2[15:8]}, 16'h0024);
    chk("l8_ttl", fr_b2[55:48], 8'h40);
    chk("l8_proto", fr_b2[63:56], 8'h11);
    chk("l8_csum", {fr_b3[7:0], fr_b3[15:8]}, 16'h26C7);
    chk("l8_last_keep", fr_keep, 8'h03);
    chk("l8_no_err", fr_err, 0);
    send_frame(14, 14, 0);
    wait_done(2);
    chk("l14_beats", fr_beats, 7);
    chk("l14_last_keep", fr_keep, 8'hFF);
    send_frame(16, 16, 0);
    wait_done(3);
    chk("l16_beats", fr_beats, 8);
    chk("l16_tail_keep", fr_keep, 8'h03);
    send_frame(24, 16, 0);
    wait_done(4);
    chk("short_err", fr_err, 1);
    chk("short_beats", fr_beats, 8);
    chk("short_last_keep", fr_keep, 8'h03);
    model_push(8, 8);
    hdr_send(8);
    repeat (4) cyc();
    chk("hdr3_csum", {m_frame_tdata[7:0], m_frame_tdata[15:8]}, 16'h26C7);
    areset = 1'b1;
    cyc();
    chk("midrst_valid", m_frame_tvalid, 0);
    chk("midrst_hdr_ready", s_hdr_tready, 0);
    chk("midrst_last", m_frame_tlast, 0);
    chk("midrst_len_err", length_err_o, 0);
    areset = 1'b0;
    #1;
    chk("midrst_ready_after", s_hdr_tready, 1);
    cyc();
    send_frame(8, 8, 0);
    wait_done(5);
    chk("after_rst_beats", fr_beats, 7);
    chk("after_rst_csum", {fr_b3[7:0], fr_b3[15:8]}, 16'h26C7);
    rand_rdy = 1'b1;
    for (int f = 0; f < 100; f++) begin
      src_port_i = 16'($urandom);
      send_frame(f % 40 + 1, f % 40 + 1, 0);
    end
    wait_done(105);
    rand_rdy = 1'b0;
    repeat (3) cyc();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
